mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multiply/divide unit in the E stage of the P6 five-stage MIPS pipeline. It is the consumer of the decoder's 4-bit MDU operation code. It executes mult/multu/div/divu over a fixed multi-cycle latency, owns the HI/LO registers, services mthi/mtlo writes and mfhi/mflo reads, and reports busy so the hazard unit can stall D-stage MDU instructions.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- start  input  1  valid MDU instruction in E this cycle; qualifies MDUControl
- MDUControl  input  4  op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
- A  input  32  forwarded rs value (dividend / multiplicand / mt source)
- B  input  32  forwarded rt value (divisor / multiplier)
- busy  output  1  operation in progress
- HI  output  32  committed HI register
- LO  output  32  committed LO register
- MDUOut  output  32  HI if MDUControl==5, LO if ==6, else 0 (combinational)

## Operation
- FSM states: IDLE, BUSY. Counter width covers max(MULT_CYCLES, DIV_CYCLES).
- IDLE, start=1, op 1–4: register the 64-bit result computed from A/B at this edge into pending {hi,lo}; load counter with MULT_CYCLES or DIV_CYCLES; go to BUSY.
- BUSY: busy=1; counter decrements each edge; on the edge where counter==1, commit pending to HI/LO and return to IDLE.
- mult: signed 32×32→64, HI=upper, LO=lower. multu: unsigned.
- div: LO=signed quotient truncated toward zero, HI=remainder (sign of dividend). divu: unsigned.
- Divide by zero: full DIV_CYCLES busy period; HI/LO not modified at commit.
- mthi/mtlo with start=1 in IDLE: HI/LO ← A at that edge; no busy.
- start=1 while BUSY: ignored (hazard unit guarantees it never occurs; the RTL must still not corrupt state).
- op 0, 5, 6, or values >8 with start: no state change.
- mfhi/mflo read committed HI/LO only; pending results are never visible.
- Hazard contract: the D-stage MDU instruction stalls while (start & op∈1–4) | busy.

## Timing
- Reset: busy=0, HI=0, LO=0, state IDLE, counter=0, pending=0. Reset mid-BUSY aborts with no commit.
- start edge = cycle 0. busy high in cycles 1..N (N = MULT_CYCLES or DIV_CYCLES). The new HI/LO is visible from cycle N+1. busy is low in cycle N+1.
- Back-to-back: a start in cycle N+1 is accepted.
- mthi/mtlo: the written value is visible in the next cycle.
- MDUOut has zero-cycle latency from MDUControl.

## Configuration
- MDU_DIV_EN defined: div/divu are implemented as above.
- MDU_DIV_EN undefined: ops 3/4 are treated as no-ops. No busy is asserted, HI/LO are unchanged, and no divider logic is synthesised.

## Structure
- Package mdu_pkg:
  - op code constants MDU_NONE…MDU_MTLO (0–8)
  - FSM state typedef
  - default cycle counts
- One sub-module, mdu_compute: combinational 64-bit result from op, A and B, plus a div-by-zero flag. The FSM and registers stay in mult_div_unit.

## Test plan
- mult A=0xFFFFFFFD (−3), B=5 -> busy for cycles 1–5; HI=0xFFFFFFFF, LO=0xFFFFFFF1 in cycle 6.
- multu A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div A=0xFFFFFFF9 (−7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 -> HI/LO unchanged after 10 cycles.
- mthi A=0x12345678, next cycle op=5 -> MDUOut=0x12345678. mtlo A=0xA5A5A5A5 -> LO=0xA5A5A5A5.
- Start mult 3×4, then assert start with divu 9/3 in cycle 2 -> ignored; HI=0, LO=12; busy falls after cycle 5.
- Start div 100/7, assert reset in cycle 4 -> busy=0, HI=LO=0 next cycle; no late commit.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared MDU op codes, FSM state type and default latencies.
// The MDU_DIV_EN macro controls whether div/divu count as busy operations.
package mdu_pkg;
  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {S_IDLE, S_BUSY} mdu_state_e;

  // Ops that occupy the unit for a multi-cycle busy period.
  function automatic logic is_long_op(input logic [3:0] op);
`ifdef MDU_DIV_EN
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
`else
    return (op == MDU_MULT) || (op == MDU_MULTU);
`endif
  endfunction
endpackage

// File: rtl/mdu_compute.sv
// Combinational 64-bit {hi,lo} result for mult/multu/div/divu plus divide-by-zero flag.
// Divider logic exists only when MDU_DIV_EN is defined.
module mdu_compute
  import mdu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_result,
  output logic        o_div0
);
  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;

  assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

`ifdef MDU_DIV_EN
  logic [31:0] w_div;
  logic [31:0] w_sq, w_sr, w_uq, w_ur;

  // Substitute 1 for a zero divisor so the datapath never produces X; commit is suppressed anyway.
  assign w_div = (i_b == 32'd0) ? 32'd1 : i_b;
  assign w_sq  = 32'($signed(i_a) / $signed(w_div));
  assign w_sr  = 32'($signed(i_a) % $signed(w_div));
  assign w_uq  = i_a / w_div;
  assign w_ur  = i_a % w_div;
`endif

  always_comb begin
    o_result = '0;
    o_div0   = 1'b0;
    case (i_op)
      MDU_MULT:  o_result = w_prod_s;
      MDU_MULTU: o_result = w_prod_u;
`ifdef MDU_DIV_EN
      MDU_DIV: begin
        o_result = {w_sr, w_sq};
        o_div0   = (i_b == 32'd0);
      end
      MDU_DIVU: begin
        o_result = {w_ur, w_uq};
        o_div0   = (i_b == 32'd0);
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: fixed-latency busy FSM, HI/LO ownership, mt/mf access.
// Define MDU_DIV_EN to implement div/divu; otherwise ops 3/4 are no-ops.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUControl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  mdu_state_e  r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [63:0] r_pend;
  logic        r_pend_div0;
  logic [31:0] r_hi, r_lo;

  logic [63:0] w_res;
  logic        w_div0;
  logic        w_idle, w_accept, w_last;

  mdu_compute u_compute (
    .i_op     (MDUControl),
    .i_a      (A),
    .i_b      (B),
    .o_result (w_res),
    .o_div0   (w_div0)
  );

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = start && w_idle && is_long_op(MDUControl);
  assign w_last   = (r_state == S_BUSY) && (r_cnt == CW'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_BUSY;
      S_BUSY: if (w_last)   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pend      <= '0;
      r_pend_div0 <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_pend      <= w_res;
        r_pend_div0 <= w_div0;
        r_cnt       <= (MDUControl == MDU_MULT || MDUControl == MDU_MULTU) ?
                       CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt - CW'(1);
        // A zero-divisor divide still burns its full latency but leaves HI/LO alone.
        if (w_last && !r_pend_div0) begin
          r_hi <= r_pend[63:32];
          r_lo <= r_pend[31:0];
        end
      end else if (start && w_idle) begin
        if (MDUControl == MDU_MTHI) r_hi <= A;
        if (MDUControl == MDU_MTLO) r_lo <= A;
      end
    end
  end

  assign busy   = (r_state == S_BUSY);
  assign HI     = r_hi;
  assign LO     = r_lo;
  assign MDUOut = (MDUControl == MDU_MFHI) ? r_hi :
                  (MDUControl == MDU_MFLO) ? r_lo : 32'd0;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table plus scoreboard queue,
// with hand sequences for ignored start, mf reads and mid-operation reset.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  MDUControl;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO, MDUOut;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a, b;
    int          n;
    logic        kh, kl;
    logic [31:0] eh, el;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
  } exp_t;

  exp_t sb[$];
  logic [31:0] m_hi, m_lo;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .MDUControl(MDUControl),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .MDUOut(MDUOut)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = s; MDUControl = op; A = a; B = b;
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      chk({name, ".hi"}, HI, e.hi);
      chk({name, ".lo"}, LO, e.lo);
      m_hi = e.hi;
      m_lo = e.lo;
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    drive(1'b1, v.op, v.a, v.b);
    e.hi = v.kh ? m_hi : v.eh;
    e.lo = v.kl ? m_lo : v.el;
    tick();
    sb.push_back(e);
    drive(1'b0, MDU_NONE, 32'd0, 32'd0);
    for (int k = 1; k <= v.n; k++) begin
      chk({v.name, ".busy"}, {31'd0, busy}, 32'd1);
      if (k == 1) chk({v.name, ".hidden"}, HI, m_hi);
      tick();
    end
    chk({v.name, ".done"}, {31'd0, busy}, 32'd0);
    pop_check(v.name);
  endtask

  vec_t vecs[12];

  initial begin
    int dn;
    logic dk;
`ifdef MDU_DIV_EN
    dn = DIV_CYCLES_DEF; dk = 1'b0;
`else
    dn = 0;              dk = 1'b1;
`endif
    vecs[0]  = '{"mult_neg3x5",  MDU_MULT,  32'hFFFFFFFD, 32'd5,        5, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1]  = '{"multu_ffx2",   MDU_MULTU, 32'hFFFFFFFF, 32'd2,        5, 1'b0, 1'b0, 32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{"multu_ffxff",  MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000001};
    vecs[3]  = '{"mult_minxmin", MDU_MULT,  32'h80000000, 32'h80000000, 5, 1'b0, 1'b0, 32'h40000000, 32'h00000000};
    vecs[4]  = '{"mult_7xneg3",  MDU_MULT,  32'd7,        32'hFFFFFFFD, 5, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[5]  = '{"div_neg7by2",  MDU_DIV,   32'hFFFFFFF9, 32'd2,        dn, dk,  dk,   32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[6]  = '{"div_7byneg2",  MDU_DIV,   32'd7,        32'hFFFFFFFE, dn, dk,  dk,   32'h00000001, 32'hFFFFFFFD};
    vecs[7]  = '{"divu_100by7",  MDU_DIVU,  32'd100,      32'd7,        dn, dk,  dk,   32'h00000002, 32'h0000000E};
    vecs[8]  = '{"divu_7by0",    MDU_DIVU,  32'd7,        32'd0,        dn, 1'b1, 1'b1, 32'd0,       32'd0};
    vecs[9]  = '{"mthi",         MDU_MTHI,  32'h12345678, 32'd0,        0, 1'b0, 1'b1, 32'h12345678, 32'd0};
    vecs[10] = '{"mtlo",         MDU_MTLO,  32'hA5A5A5A5, 32'd0,        0, 1'b1, 1'b0, 32'd0,        32'hA5A5A5A5};
    vecs[11] = '{"op_invalid",   4'd12,     32'hDEADBEEF, 32'd3,        0, 1'b1, 1'b1, 32'd0,        32'd0};

    reset = 1'b1;
    drive(1'b0, MDU_NONE, 32'd0, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    tick(); tick();
    reset = 1'b0;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.hi", HI, 32'd0);
    chk("rst.lo", LO, 32'd0);

    // Start while busy must be ignored.
    drive(1'b1, MDU_MULT, 32'd3, 32'd4);
    tick();
    sb.push_back('{hi: 32'd0, lo: 32'd12});
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) drive(1'b1, MDU_DIVU, 32'd9, 32'd3);
      else        drive(1'b0, MDU_NONE, 32'd0, 32'd0);
      chk("ign.busy", {31'd0, busy}, 32'd1);
      tick();
    end
    drive(1'b0, MDU_NONE, 32'd0, 32'd0);
    chk("ign.done", {31'd0, busy}, 32'd0);
    pop_check("ign");

    // Back-to-back: the table starts in the first idle cycle.
    foreach (vecs[i]) run_vec(vecs[i]);

    MDUControl = MDU_MFHI; #1;
    chk("mfhi", MDUOut, m_hi);
    MDUControl = MDU_MFLO; #1;
    chk("mflo", MDUOut, m_lo);
    MDUControl = MDU_NONE; #1;
    chk("mf_none", MDUOut, 32'd0);

    // mfhi after mthi in the very next cycle.
    drive(1'b1, MDU_MTHI, 32'hCAFEF00D, 32'd0);
    tick();
    drive(1'b1, MDU_MFHI, 32'd0, 32'd0);
    #1;
    chk("mthi_mfhi", MDUOut, 32'hCAFEF00D);
    m_hi = 32'hCAFEF00D;
    tick();
    chk("mfhi_nochg", HI, 32'hCAFEF00D);

    // Reset in cycle 4 of a long op aborts without commit.
`ifdef MDU_DIV_EN
    drive(1'b1, MDU_DIV, 32'd100, 32'd7);
`else
    drive(1'b1, MDU_MULT, 32'd100, 32'd7);
`endif
    tick();
    drive(1'b0, MDU_NONE, 32'd0, 32'd0);
    tick(); tick(); tick();
    chk("rmid.busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmid.busy0", {31'd0, busy}, 32'd0);
    chk("rmid.hi", HI, 32'd0);
    chk("rmid.lo", LO, 32'd0);
    for (int c = 0; c < 12; c++) tick();
    chk("rmid.late_hi", HI, 32'd0);
    chk("rmid.late_lo", LO, 32'd0);
    chk("rmid.late_busy", {31'd0, busy}, 32'd0);

    chk("sb.empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
